// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: turn sequencer for a 9-cell tic-tac-toe board array.
//
// Takes move requests from players A and B and enforces turn order and legality.
// Each legal move runs the board through read, check, write and checkwin steps.
// The controller then reports win, draw and game-over status. It is the only
// master of the board's op, index and data lines.
//
// Ports:
//   clk_i, rst_ni                     clock (rising edge), async active-low reset
//   start_i                           pulse: clear board, start a new game (any state)
//   move_valid_i/player_i/pos_i       move request, held until ack/nack
//   move_ack_o, move_nack_o           one-cycle result pulses
//   tbl_clr_o, tbl_op_o, tbl_index_o  board control (op: 00 idle, 01 chk, 10 wr, 11 rd)
//   tbl_wdata_o, tbl_data_oe_o        write code (A=11, B=10) and its enable
//   tbl_rdata_i                       read code from board, 00 = empty
//   tbl_game_end_i, tbl_winner_i      checkwin result (winner 1 = A)
//   cur_player_o, busy_o, game_over_o status
//   result_o                          00 none, 01 A, 10 B, 11 draw
//   move_count_o, timeout_o           committed moves, forfeit flag
//
// Optional feature: define TURN_TIMEOUT_EN to forfeit a player who idles in TURN
// for TIMEOUT_CYCLES cycles. Without it timeout_o is constant 0.
// All outputs are registered and are decoded from the next state.

module ttt_game_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 10
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       move_valid_i,
    input  logic       move_player_i,
    input  logic [3:0] move_pos_i,
    output logic       move_ack_o,
    output logic       move_nack_o,
    output logic       tbl_clr_o,
    output logic [1:0] tbl_op_o,
    output logic [3:0] tbl_index_o,
    output logic [1:0] tbl_wdata_o,
    output logic       tbl_data_oe_o,
    input  logic [1:0] tbl_rdata_i,
    input  logic       tbl_game_end_i,
    input  logic       tbl_winner_i,
    output logic       cur_player_o,
    output logic       busy_o,
    output logic       game_over_o,
    output logic [1:0] result_o,
    output logic [3:0] move_count_o,
    output logic       timeout_o
);

    typedef enum logic [3:0] {
        StIdle, StClear, StTurn, StRd, StChk, StWr, StCw, StEval, StRelease, StDone
    } state_e;

    localparam logic [1:0] OpIdle = 2'b00;
    localparam logic [1:0] OpChk  = 2'b01;
    localparam logic [1:0] OpWr   = 2'b10;
    localparam logic [1:0] OpRd   = 2'b11;

    state_e     state_q, state_d;
    logic [3:0] pos_q, pos_d;
    logic [1:0] rcode_q, rcode_d;
    logic       gend_q, gend_d;
    logic       gwin_q, gwin_d;
    // In IDLE/DONE: the current request was already nacked, wait for it to drop.
    logic       hold_q, hold_d;

    logic       ack_q, ack_d;
    logic       nack_q, nack_d;
    logic       clr_q, clr_d;
    logic [1:0] op_q, op_d;
    logic [3:0] index_q, index_d;
    logic [1:0] wdata_q, wdata_d;
    logic       oe_q, oe_d;
    logic       cur_q, cur_d;
    logic       busy_q, busy_d;
    logic       over_q, over_d;
    logic [1:0] result_q, result_d;
    logic [3:0] count_q, count_d;
    logic       timeout_q, timeout_d;
    logic       expire;

`ifdef TURN_TIMEOUT_EN
    logic [CNT_W-1:0] tcnt_q, tcnt_d;

    assign expire = (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive cycles spent in TURN; clears on any exit.
    always_comb begin
        tcnt_d = '0;
        if (state_q == StTurn && state_d == StTurn) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
    assign expire     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        rcode_d   = rcode_q;
        gend_d    = gend_q;
        gwin_d    = gwin_q;
        hold_d    = hold_q;
        ack_d     = 1'b0;
        nack_d    = 1'b0;
        cur_d     = cur_q;
        result_d  = result_q;
        count_d   = count_q;
        timeout_d = timeout_q;

        if (start_i) begin
            state_d   = StClear;
            cur_d     = 1'b0;
            result_d  = 2'b00;
            count_d   = 4'd0;
            timeout_d = 1'b0;
            hold_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (!hold_q && move_valid_i) begin
                        nack_d = 1'b1;
                        hold_d = 1'b1;
                    end else if (hold_q && !move_valid_i) begin
                        hold_d = 1'b0;
                    end
                end
                StClear: state_d = StTurn;
                StTurn: begin
                    if (move_valid_i) begin
                        pos_d = move_pos_i;
                        if (move_player_i != cur_q || move_pos_i > 4'd8) begin
                            nack_d  = 1'b1;
                            state_d = StRelease;
                        end else begin
                            state_d = StRd;
                        end
                    end else if (expire) begin
                        // The idle player forfeits; the other one wins.
                        result_d  = cur_q ? 2'b01 : 2'b10;
                        timeout_d = 1'b1;
                        hold_d    = 1'b1;
                        state_d   = StDone;
                    end
                end
                StRd: begin
                    rcode_d = tbl_rdata_i;
                    state_d = StChk;
                end
                StChk: begin
                    if (rcode_q != 2'b00) begin
                        nack_d  = 1'b1;
                        state_d = StRelease;
                    end else begin
                        state_d = StWr;
                    end
                end
                StWr: state_d = StCw;
                StCw: begin
                    gend_d  = tbl_game_end_i;
                    gwin_d  = tbl_winner_i;
                    state_d = StEval;
                end
                StEval: begin
                    count_d = count_q + 4'd1;
                    ack_d   = 1'b1;
                    if (gend_q) begin
                        result_d = gwin_q ? 2'b01 : 2'b10;
                        hold_d   = 1'b1;
                        state_d  = StDone;
                    end else if (count_d == 4'd9) begin
                        result_d = 2'b11;
                        hold_d   = 1'b1;
                        state_d  = StDone;
                    end else begin
                        cur_d   = ~cur_q;
                        state_d = StRelease;
                    end
                end
                StRelease: begin
                    if (!move_valid_i) begin
                        state_d = StTurn;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Board-facing and status outputs follow the state being entered.
    always_comb begin
        op_d    = OpIdle;
        index_d = 4'd0;
        wdata_d = 2'b00;
        oe_d    = 1'b0;
        unique case (state_d)
            StRd: begin
                op_d    = OpRd;
                index_d = pos_d;
            end
            StWr: begin
                op_d    = OpWr;
                index_d = pos_d;
                wdata_d = {1'b1, ~cur_q};
                oe_d    = 1'b1;
            end
            StCw:    op_d = OpChk;
            default: op_d = OpIdle;
        endcase
        clr_d  = (state_d == StClear);
        over_d = (state_d == StDone);
        busy_d = (state_d == StRd) || (state_d == StChk) || (state_d == StWr) ||
                 (state_d == StCw) || (state_d == StEval);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            pos_q     <= 4'd0;
            rcode_q   <= 2'b00;
            gend_q    <= 1'b0;
            gwin_q    <= 1'b0;
            hold_q    <= 1'b0;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
            clr_q     <= 1'b0;
            op_q      <= OpIdle;
            index_q   <= 4'd0;
            wdata_q   <= 2'b00;
            oe_q      <= 1'b0;
            cur_q     <= 1'b0;
            busy_q    <= 1'b0;
            over_q    <= 1'b0;
            result_q  <= 2'b00;
            count_q   <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            rcode_q   <= rcode_d;
            gend_q    <= gend_d;
            gwin_q    <= gwin_d;
            hold_q    <= hold_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
            clr_q     <= clr_d;
            op_q      <= op_d;
            index_q   <= index_d;
            wdata_q   <= wdata_d;
            oe_q      <= oe_d;
            cur_q     <= cur_d;
            busy_q    <= busy_d;
            over_q    <= over_d;
            result_q  <= result_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign move_ack_o    = ack_q;
    assign move_nack_o   = nack_q;
    assign tbl_clr_o     = clr_q;
    assign tbl_op_o      = op_q;
    assign tbl_index_o   = index_q;
    assign tbl_wdata_o   = wdata_q;
    assign tbl_data_oe_o = oe_q;
    assign cur_player_o  = cur_q;
    assign busy_o        = busy_q;
    assign game_over_o   = over_q;
    assign result_o      = result_q;
    assign move_count_o  = count_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb_ttt_game_ctrl: directed self-checking bench for ttt_game_ctrl.
// A small behavioural board array answers read/write/checkwin operations.

module tb_ttt_game_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       move_valid;
    logic       move_player;
    logic [3:0] move_pos;
    logic       move_ack;
    logic       move_nack;
    logic       tbl_clr;
    logic [1:0] tbl_op;
    logic [3:0] tbl_index;
    logic [1:0] tbl_wdata;
    logic       tbl_data_oe;
    logic [1:0] tbl_rdata;
    logic       tbl_game_end;
    logic       tbl_winner;
    logic       cur_player;
    logic       busy;
    logic       game_over;
    logic [1:0] result;
    logic [3:0] move_count;
    logic       timeout;

    int n_chk = 0;
    int n_bad = 0;
    int n_op  = 0;
    int n_wr  = 0;

    ttt_game_ctrl #(
        .TIMEOUT_CYCLES(8),
        .CNT_W         (10)
    ) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .move_valid_i  (move_valid),
        .move_player_i (move_player),
        .move_pos_i    (move_pos),
        .move_ack_o    (move_ack),
        .move_nack_o   (move_nack),
        .tbl_clr_o     (tbl_clr),
        .tbl_op_o      (tbl_op),
        .tbl_index_o   (tbl_index),
        .tbl_wdata_o   (tbl_wdata),
        .tbl_data_oe_o (tbl_data_oe),
        .tbl_rdata_i   (tbl_rdata),
        .tbl_game_end_i(tbl_game_end),
        .tbl_winner_i  (tbl_winner),
        .cur_player_o  (cur_player),
        .busy_o        (busy),
        .game_over_o   (game_over),
        .result_o      (result),
        .move_count_o  (move_count),
        .timeout_o     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- board model ----------------
    logic [1:0] board [9];
    logic [1:0] ln [8];

    function automatic logic [1:0] line3(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c);
        return (a != 2'b00 && a == b && b == c) ? a : 2'b00;
    endfunction

    assign ln[0] = line3(board[0], board[1], board[2]);
    assign ln[1] = line3(board[3], board[4], board[5]);
    assign ln[2] = line3(board[6], board[7], board[8]);
    assign ln[3] = line3(board[0], board[3], board[6]);
    assign ln[4] = line3(board[1], board[4], board[7]);
    assign ln[5] = line3(board[2], board[5], board[8]);
    assign ln[6] = line3(board[0], board[4], board[8]);
    assign ln[7] = line3(board[2], board[4], board[6]);

    always_comb begin
        tbl_game_end = 1'b0;
        tbl_winner   = 1'b0;
        if (tbl_op == 2'b01) begin
            for (int i = 0; i < 8; i++) begin
                if (ln[i] != 2'b00) begin
                    tbl_game_end = 1'b1;
                    tbl_winner   = (ln[i] == 2'b11);
                end
            end
        end
    end

    assign tbl_rdata = (tbl_op == 2'b11 && tbl_index < 4'd9) ? board[tbl_index] : 2'b00;

    always @(posedge clk) begin
        if (tbl_clr) begin
            for (int i = 0; i < 9; i++) board[i] <= 2'b00;
        end else if (tbl_op == 2'b10 && tbl_data_oe && tbl_index < 4'd9) begin
            board[tbl_index] <= tbl_wdata;
        end
        if (tbl_op != 2'b00) n_op <= n_op + 1;
        if (tbl_op == 2'b10) n_wr <= n_wr + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a request, wait (bounded) for ack/nack, then release and settle in TURN.
    // kind: 1 = ack, 2 = nack, 0 = none within budget.
    task automatic req(input logic pl, input logic [3:0] pos, output int lat, output int kind);
        move_player = pl;
        move_pos    = pos;
        move_valid  = 1'b1;
        lat  = 99;
        kind = 0;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            if (move_ack || move_nack) begin
                lat  = n;
                kind = move_ack ? 1 : 2;
                break;
            end
        end
        move_valid = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic move(input string tag, input logic pl, input logic [3:0] pos,
                        input int exp_kind, input int exp_lat);
        int lat;
        int kind;
        req(pl, pos, lat, kind);
        check({tag, "_kind"}, kind, exp_kind);
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic new_game();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] draw_pos [9];
    int op0;
    int wr0;
    int seen_ack;
    int seen_clr;
    int tlat;

    initial begin
        draw_pos = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
        rst_n       = 1'b0;
        start       = 1'b0;
        move_valid  = 1'b0;
        move_player = 1'b0;
        move_pos    = 4'd0;
        repeat (2) @(negedge clk);

        check("rst_op", tbl_op, 0);
        check("rst_count", move_count, 0);
        check("rst_status", {game_over, busy, tbl_clr, move_ack, move_nack, timeout}, 0);
        check("rst_result", result, 0);
        check("rst_cur", cur_player, 0);
        rst_n = 1'b1;
        cyc();

        // request before any start is refused
        move("idle_req", 1'b0, 4'd0, 2, 1);

        // start pulse
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("clr_on", tbl_clr, 1);
        check("clr_count", move_count, 0);
        check("clr_result", result, 0);
        check("clr_cur", cur_player, 0);
        cyc();
        check("clr_off", tbl_clr, 0);

        // A wins on the top row
        move("win_a0", 1'b0, 4'd0, 1, 6);
        move("win_b3", 1'b1, 4'd3, 1, 6);
        move("win_a1", 1'b0, 4'd1, 1, 6);
        move("win_b4", 1'b1, 4'd4, 1, 6);
        move("win_a2", 1'b0, 4'd2, 1, 6);
        check("win_result", result, 1);
        check("win_over", game_over, 1);
        check("win_count", move_count, 5);

        // illegal player and illegal position
        new_game();
        op0 = n_op;
        move("wrong_player", 1'b1, 4'd0, 2, 1);
        check("wrong_player_cur", cur_player, 0);
        move("bad_pos", 1'b0, 4'd9, 2, 1);
        check("bad_pos_ops", n_op - op0, 0);
        check("bad_pos_cur", cur_player, 0);

        // occupied cell
        move("occ_a4", 1'b0, 4'd4, 1, 6);
        wr0 = n_wr;
        move("occ_b4", 1'b1, 4'd4, 2, 3);
        check("occ_writes", n_wr - wr0, 0);
        check("occ_count", move_count, 1);
        check("occ_cur", cur_player, 1);

        // draw after nine moves
        new_game();
        for (int i = 0; i < 9; i++) begin
            move($sformatf("draw_%0d", i), 1'(i % 2), draw_pos[i], 1, 6);
        end
        check("draw_result", result, 3);
        check("draw_count", move_count, 9);
        check("draw_over", game_over, 1);
        move("draw_tenth", 1'b0, 4'd0, 2, 1);

`ifdef TURN_TIMEOUT_EN
        // A idles: forfeits at the end of the 8th TURN cycle
        start = 1'b1;
        tlat  = 99;
        for (int n = 1; n <= 30; n++) begin
            cyc();
            start = 1'b0;
            if (timeout) begin
                tlat = n;
                break;
            end
        end
        check("to_lat", tlat, 10);
        check("to_result", result, 2);
        check("to_over", game_over, 1);
`else
        new_game();
        repeat (20) cyc();
        check("noto_flag", timeout, 0);
        check("noto_over", game_over, 0);
`endif

        // start mid-move drops the in-flight move
        new_game();
        move_player = 1'b0;
        move_pos    = 4'd5;
        move_valid  = 1'b1;
        cyc();
        cyc();
        cyc();
        start      = 1'b1;
        move_valid = 1'b0;
        seen_ack = 0;
        seen_clr = 0;
        for (int n = 0; n < 10; n++) begin
            cyc();
            start = 1'b0;
            if (move_ack) seen_ack++;
            if (tbl_clr) seen_clr++;
        end
        check("mid_ack", seen_ack, 0);
        check("mid_clr", seen_clr, 1);
        check("mid_count", move_count, 0);
        check("mid_cur", cur_player, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
